// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage.
//   fetch_state_t : BOOT / RUN / FAULT control states of fetch_stage
//   NOP_INSTR     : canonical bubble word (addi x0, x0, 0)
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//   clk, rst        : clock, synchronous active-high reset
//   hold            : keep all contents (stall)
//   flush           : insert a bubble (valid=0, instr=NOP); wins over hold
//   pc_in, pc_plus4_in, instr_in : fetch-side data captured on a normal load
//   valid, pc, pc_plus4, instr   : registered outputs toward decode
module ifid_reg import fetch_pkg::*; #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hold,
  input  logic                         flush,
  input  logic [ADDRESS_WIDTH-1:0]     pc_in,
  input  logic [ADDRESS_WIDTH-1:0]     pc_plus4_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
  output logic                         valid,
  output logic [ADDRESS_WIDTH-1:0]     pc,
  output logic [ADDRESS_WIDTH-1:0]     pc_plus4,
  output logic [INSTRUCTION_WIDTH-1:0] instr
);

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(NOP_INSTR);

  logic                         valid_d, valid_q;
  logic [ADDRESS_WIDTH-1:0]     pc_d, pc_q;
  logic [ADDRESS_WIDTH-1:0]     pc_plus4_d, pc_plus4_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_d, instr_q;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (flush) begin
      // pc fields keep their last value; only valid/instr mark the bubble
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (!hold) begin
      valid_d    = 1'b1;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
      instr_d    = instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign valid    = valid_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;
  assign instr    = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and fills the IF/ID register.
//   clk, rst     : clock, synchronous active-high reset
//   stall        : hold PC and IF/ID
//   redirect     : load pc_target, bubble IF/ID (overrides stall)
//   pc_target    : redirect destination
//   imem_addr    : registered PC toward instruction memory
//   imem_instr   : word returned for imem_addr
//   ifid_*       : IF/ID register contents for decode
//   fetch_fault  : misaligned redirect trapped
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect
// parks the stage in FAULT until reset. Without it the low two target bits
// are cleared and fetch_fault is constant 0.
module fetch_stage import fetch_pkg::*; #(
  parameter int                       ADDRESS_WIDTH     = 32,
  parameter int                       INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR      = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [ADDRESS_WIDTH-1:0]     pc_target,
  output logic [ADDRESS_WIDTH-1:0]     imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instr,
  output logic                         ifid_valid,
  output logic [ADDRESS_WIDTH-1:0]     ifid_pc,
  output logic [ADDRESS_WIDTH-1:0]     ifid_pc_plus4,
  output logic [INSTRUCTION_WIDTH-1:0] ifid_instr,
  output logic                         fetch_fault
);

  fetch_state_t             state_d, state_q;
  logic [ADDRESS_WIDTH-1:0] pc_d, pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     ifid_hold, ifid_flush;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                     fault_d, fault_q;
`else
  logic                     unused_target_lo;
  assign unused_target_lo = ^pc_target[1:0];
`endif

  // Wraps modulo 2^ADDRESS_WIDTH by construction.
  assign pc_plus4 = pc_q + ADDRESS_WIDTH'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      // One-cycle bubble after reset; stall/redirect are ignored here.
      BOOT: begin
        state_d    = RUN;
        ifid_flush = 1'b1;
      end
      RUN: begin
        if (redirect) begin
          ifid_flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_target[1:0] != 2'b00) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_target;
          end
`else
          pc_d = {pc_target[ADDRESS_WIDTH-1:2], 2'b00};
`endif
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else begin
          pc_d = pc_plus4;
        end
      end
      FAULT: begin
        ifid_flush = 1'b1;
      end
      default: begin
        state_d    = BOOT;
        ifid_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign imem_addr = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  ifid_reg #(
    .ADDRESS_WIDTH    (ADDRESS_WIDTH),
    .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH)
  ) u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .hold       (ifid_hold),
    .flush      (ifid_flush),
    .pc_in      (pc_q),
    .pc_plus4_in(pc_plus4),
    .instr_in   (imem_instr),
    .valid      (ifid_valid),
    .pc         (ifid_pc),
    .pc_plus4   (ifid_pc_plus4),
    .instr      (ifid_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] pc_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        fetch_fault;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  // Address-tagged memory contents: word at A reads as 0xA000_0000 | A.
  assign imem_instr = 32'hA000_0000 | imem_addr;

  fetch_stage u_dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .pc_target    (pc_target),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_instr   (ifid_instr),
    .fetch_fault  (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 32'(ifid_valid), 32'd0);
    chk({tag, "_instr"}, ifid_instr, NOP);
  endtask

  task automatic chk_valid(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(ifid_valid), 32'd1);
    chk({tag, "_pc"}, ifid_pc, pc);
    chk({tag, "_pc4"}, ifid_pc_plus4, pc + 32'd4);
    chk({tag, "_instr"}, ifid_instr, 32'hA000_0000 | pc);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk_bubble(tag);
    chk({tag, "_pc"}, ifid_pc, 32'h0);
    chk({tag, "_pc4"}, ifid_pc_plus4, 32'h0);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; pc_target = 32'h0;
    step(); step();
    chk_reset("rst");

    // BOOT bubble, then sequential fetch
    rst = 1'b0;
    step();
    chk_bubble("boot");
    chk("boot_addr", imem_addr, 32'h0);
    step();
    chk_valid("run0", 32'h0);
    chk("run0_addr", imem_addr, 32'h4);
    step();
    chk_valid("run4", 32'h4);
    chk("run4_addr", imem_addr, 32'h8);

    // Stall three cycles at PC=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_valid("stall", 32'h4);
      chk("stall_addr", imem_addr, 32'h8);
    end
    stall = 1'b0;
    step();
    chk_valid("resume", 32'h8);
    chk("resume_addr", imem_addr, 32'hC);

    // Redirect with stall also high: redirect wins, one bubble
    redirect = 1'b1; stall = 1'b1; pc_target = 32'h40;
    step();
    chk_bubble("redir");
    chk("redir_addr", imem_addr, 32'h40);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk_valid("redir_tgt", 32'h40);
    chk("redir_tgt_addr", imem_addr, 32'h44);

    // PC wrap
    redirect = 1'b1; pc_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_load", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step();
    chk_valid("wrap", 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_fault", 32'(fetch_fault), 32'd0);

    // Misaligned redirect
    redirect = 1'b1; pc_target = 32'h42;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_addr", imem_addr, 32'h0);
    chk_bubble("mis");
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("flt_fault", 32'(fetch_fault), 32'd1);
      chk("flt_addr", imem_addr, 32'h0);
      chk_bubble("flt");
    end
`else
    chk("mis_fault", 32'(fetch_fault), 32'd0);
    chk("mis_addr", imem_addr, 32'h40);
    chk_bubble("mis");
    redirect = 1'b0;
    step();
    chk_valid("mis_tgt", 32'h40);
    chk("mis_tgt_addr", imem_addr, 32'h44);
`endif

    // Reset during redirect+stall wins
    rst = 1'b1; redirect = 1'b1; stall = 1'b1; pc_target = 32'h80;
    step();
    chk_reset("rst2");
    rst = 1'b0; redirect = 1'b0; stall = 1'b0;
    step();
    chk_bubble("boot2");
    chk("boot2_addr", imem_addr, 32'h0);
    step();
    chk_valid("run2", 32'h0);
    chk("run2_addr", imem_addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Owns the program counter, drives the address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for the decoder. Handles stalls from hazard detection and redirects from branch/jump resolution, and inserts bubbles where required.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, PC and memory address width
- INSTRUCTION_WIDTH, 32, instruction word width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC and IF/ID contents (load-use hazard)
- redirect  in  1  taken branch/jump resolved downstream; kill in-flight fetch
- pc_target  in  ADDRESS_WIDTH  redirect destination
- imem_addr  out  ADDRESS_WIDTH  byte address to instruction memory (equals PC)
- imem_instr  in  INSTRUCTION_WIDTH  word returned combinationally by instruction memory
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_pc  out  ADDRESS_WIDTH  address of ifid_instr
- ifid_pc_plus4  out  ADDRESS_WIDTH  ifid_pc + 4
- ifid_instr  out  INSTRUCTION_WIDTH  captured instruction, NOP when bubble
- fetch_fault  out  1  misaligned redirect trapped (see Configuration)

## Operation
- States: BOOT, RUN, FAULT.
- BOOT: entered on rst. PC = RESET_VECTOR, ifid_valid = 0. redirect and stall ignored. Next cycle → RUN unconditionally.
- RUN, each edge, priority order:
  - redirect=1: PC ← pc_target; ifid_valid ← 0, ifid_instr ← NOP. Overrides stall.
  - stall=1 (no redirect): PC and all ifid_* hold.
  - otherwise: ifid_instr ← imem_instr, ifid_pc ← PC, ifid_pc_plus4 ← PC+4, ifid_valid ← 1; PC ← PC+4.
- PC arithmetic modulo 2^ADDRESS_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- FAULT (only with macro): PC frozen, ifid_valid = 0, ifid_instr = NOP, fetch_fault = 1; exits only via rst.
- rst at any time, including mid-stall or same cycle as redirect: wins; all state to reset values next edge.

## Timing
- Reset values: imem_addr = RESET_VECTOR, ifid_valid = 0, ifid_instr = NOP (32'h0000_0013), ifid_pc = 0, ifid_pc_plus4 = 0, fetch_fault = 0, state = BOOT.
- imem_addr is the registered PC; no combinational path from any input to imem_addr.
- Fetch-to-decode latency: 1 cycle (word at PC appears on ifid_instr after the next edge).
- First valid instruction: ifid_valid = 1 on the second edge after rst deasserts (BOOT bubble).
- Redirect penalty: 1 bubble; instruction at pc_target valid on ifid two edges after redirect sampled.
- All ifid_* outputs registered.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with pc_target[1:0] ≠ 0 sends RUN → FAULT on that edge, asserts fetch_fault, PC not updated.
- Undefined: pc_target[1:0] forced to 0 on load, fetch_fault tied 0, FAULT state unreachable.

## Structure
- Shared package fetch_pkg: fetch_state_t enum (BOOT, RUN, FAULT), NOP_INSTR constant 32'h0000_0013.
- One sub-module: ifid_reg (IF/ID register with hold and bubble-insert controls); PC and state machine stay in fetch_stage.

## Test plan
- Reset then free run from 0, imem returning addr-tagged words → ifid_valid=0 for BOOT cycle, then ifid_pc 0,4,8,… one per cycle, ifid_pc_plus4 = ifid_pc+4.
- stall high 3 cycles at PC=8 → ifid_pc=4 and ifid_instr held 3 cycles, imem_addr stays 8, resumes with ifid_pc=8.
- redirect to 0x40 with stall also high → one bubble (ifid_valid=0, ifid_instr=0x13), next valid ifid_pc=0x40.
- PC preloaded to 0xFFFF_FFFC via redirect → next imem_addr = 0, no fault.
- Macro on: redirect to 0x42 → fetch_fault=1, imem_addr frozen, ifid_valid=0 until rst; macro off: same stimulus → imem_addr=0x40, fetch_fault=0.
- rst asserted mid-stream during redirect → next edge all outputs at reset values, BOOT bubble repeats.
